// File: rtl/sad_result_collector.sv
// sad_result_collector: tracks the minimum SAD and its raster position over one block search,
// then presents the winner until acknowledged.
module sad_result_collector #(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int WIN_W   = 4,
    parameter int WIN_H   = 4,
    parameter int SAD_W   = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic             CandValid,
    input  logic [SAD_W-1:0] CandSad,
    output logic             CandReady,
    input  logic             Ack,
    output logic             Busy,
    output logic             Done,
    output logic [SAD_W-1:0] xCoord,
    output logic [SAD_W-1:0] yCoord,
    output logic [SAD_W-1:0] sad
);
    localparam int MAX_X = FRAME_W - WIN_W;
    localparam int MAX_Y = FRAME_H - WIN_H;
    localparam int XW = MAX_X > 0 ? $clog2(MAX_X + 1) : 1;
    localparam int YW = MAX_Y > 0 ? $clog2(MAX_Y + 1) : 1;
    localparam logic [XW-1:0] LAST_X = XW'(MAX_X);
    localparam logic [YW-1:0] LAST_Y = YW'(MAX_Y);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
    state_t state, state_nxt;

    logic [XW-1:0]    cur_x, best_x, nx_bx;
    logic [YW-1:0]    cur_y, best_y, nx_by;
    logic [SAD_W-1:0] best_sad, nx_bs;
    logic             xfer, last, lt, row_end;

    always_comb begin
        xfer      = CandValid && state == SCAN;
        row_end   = cur_x == LAST_X;
        last      = xfer && row_end && cur_y == LAST_Y;
        lt        = CandSad < best_sad;
        nx_bs     = lt ? CandSad : best_sad;
        nx_bx     = lt ? cur_x : best_x;
        nx_by     = lt ? cur_y : best_y;
        state_nxt = state == IDLE ? (Start ? SCAN : IDLE) :
                    state == SCAN ? (last ? HOLD : SCAN) :
                    (Ack ? IDLE : HOLD);
        CandReady = state == SCAN;
        Busy      = state == SCAN;
        Done      = state == HOLD;
    end

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cur_x    <= '0;
            cur_y    <= '0;
            best_x   <= '0;
            best_y   <= '0;
            best_sad <= '0;
            xCoord   <= '0;
            yCoord   <= '0;
            sad      <= '0;
        end else if (state == IDLE && Start) begin
            cur_x    <= '0;
            cur_y    <= '0;
            best_x   <= '0;
            best_y   <= '0;
            best_sad <= '1;
        end else if (xfer) begin
            best_sad <= nx_bs;
            best_x   <= nx_bx;
            best_y   <= nx_by;
            cur_x    <= row_end ? '0 : cur_x + 1'b1;
            cur_y    <= row_end ? cur_y + 1'b1 : cur_y;
            // the final candidate's compare result goes straight to the outputs
            if (last) begin
                xCoord <= SAD_W'(nx_bx);
                yCoord <= SAD_W'(nx_by);
                sad    <= nx_bs;
            end
        end
    end
endmodule
